// File: rtl/serial_lsb_comparator_if.sv
// Handshake and result bundle for the LSB-first serial magnitude comparator.
// The master side streams bit pairs and issues start; the slave side is the comparator.
interface serial_lsb_comparator_if;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic bit_ready;
    logic busy;
    logic done;
    logic eq;
    logic gt;
    logic lt;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  bit_ready, busy, done, eq, gt, lt
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output bit_ready, busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_lsb_comparator.sv
// Serial magnitude comparator, operands arrive LSB first, one bit pair per beat.
// A differing bit always overwrites the running verdict, so the most significant
// difference (the last one seen) decides the final result.
module serial_lsb_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_lsb_comparator_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             run_eq_q, run_eq_d;
    logic             run_gt_q, run_gt_d;
    logic             ready_q, busy_q, done_q;
    logic             eq_q, gt_q, lt_q;
    logic             beat;
    logic             diff;

    // Running verdict as it would look after accepting the current bit pair.
    always_comb begin
        beat     = bus.bit_valid && ready_q;
        diff     = bus.a_bit ^ bus.b_bit;
        run_eq_d = diff ? 1'b0      : run_eq_q;
        run_gt_d = diff ? bus.a_bit : run_gt_q;
        count_d  = count_q + 1'b1;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            run_eq_q <= 1'b1;
            run_gt_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q  <= RUN;
                        count_q  <= '0;
                        run_eq_q <= 1'b1;
                        run_gt_q <= 1'b0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here; only beats advance the run.
                    if (beat) begin
                        count_q  <= count_d;
                        run_eq_q <= run_eq_d;
                        run_gt_q <= run_gt_d;
                        if (count_q == LAST) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            eq_q    <= run_eq_d;
                            gt_q    <= run_gt_d & ~run_eq_d;
                            lt_q    <= ~run_eq_d & ~run_gt_d;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Back-to-back comparison: restart directly from DONE.
                        state_q  <= RUN;
                        count_q  <= '0;
                        run_eq_q <= 1'b1;
                        run_gt_q <= 1'b0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bit_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;

endmodule
